// File: rtl/usb_rx_pkg.sv
// Shared types and default timing constants for the serial receive path.
// The defaults describe one full-speed bit at eight system clocks.
package usb_rx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rx_timer_state_t;

    localparam int CLKS_PER_BIT  = 8;
    localparam int SAMPLE_POINT  = 3;
    localparam int BITS_PER_BYTE = 8;
    localparam int STUFF_LIMIT   = 6;

endpackage

// File: rtl/rx_flex_counter.sv
// Up-counter with synchronous clear, count enable and programmable rollover value.
// The rollover flag is combinational: high in the cycle whose enabled count wraps back to zero.
module rx_flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_count_enable,
    input  logic [WIDTH-1:0] i_rollover_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_rollover_flag
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_count_enable) begin
            r_count <= (r_count == i_rollover_val) ? '0 : r_count + 1'b1;
        end
    end

    assign o_count         = r_count;
    assign o_rollover_flag = i_count_enable && !i_clear && (r_count == i_rollover_val);

endmodule

// File: rtl/rx_bit_timer.sv
// Receive bit timer: resyncs on data edges, strobes mid-bit shifts, drops stuffed bits and flags violations.
// Strobes are decoded from registered state plus d_orig; byte_received follows the eighth accepted bit by one cycle.
module rx_bit_timer #(
    parameter int CLKS_PER_BIT  = usb_rx_pkg::CLKS_PER_BIT,
    parameter int SAMPLE_POINT  = usb_rx_pkg::SAMPLE_POINT,
    parameter int BITS_PER_BYTE = usb_rx_pkg::BITS_PER_BYTE,
    parameter int STUFF_LIMIT   = usb_rx_pkg::STUFF_LIMIT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable_timer,
    input  logic                           d_edge,
    input  logic                           d_orig,
    output logic                           shift_enable,
    output logic                           byte_received,
    output logic                           stuff_err,
    output logic [$clog2(BITS_PER_BYTE):0] bit_cnt
);

    import usb_rx_pkg::*;

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(BITS_PER_BYTE) + 1;
    localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

    rx_timer_state_t r_state;
    rx_timer_state_t w_state_nxt;

    logic [CNT_W-1:0]  w_clk_cnt;
    logic [BIT_W-1:0]  w_bit_cnt;
    logic [ONES_W-1:0] r_ones_cnt;
    logic              r_byte_received;

    logic w_run;
    logic w_leave;
    logic w_sample;
    logic w_stuff;
    logic w_accept;
    logic w_byte_done;
    logic w_unused_clk_wrap;

    assign w_run    = (r_state == RUN);
    assign w_leave  = w_run && !enable_timer;
    assign w_sample = w_run && (w_clk_cnt == CNT_W'(SAMPLE_POINT));
    assign w_stuff  = w_sample && (r_ones_cnt == ONES_W'(STUFF_LIMIT));
    assign w_accept = w_sample && !w_stuff;

    // A data edge restarts the bit period; the current cycle still samples with the old count.
    rx_flex_counter #(
        .WIDTH (CNT_W)
    ) u_clk_cnt (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_clear         (w_run && (d_edge || !enable_timer)),
        .i_count_enable  (w_run),
        .i_rollover_val  (CNT_W'(CLKS_PER_BIT - 1)),
        .o_count         (w_clk_cnt),
        .o_rollover_flag (w_unused_clk_wrap)
    );

    rx_flex_counter #(
        .WIDTH (BIT_W)
    ) u_bit_cnt (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_clear         (w_leave),
        .i_count_enable  (w_accept),
        .i_rollover_val  (BIT_W'(BITS_PER_BYTE - 1)),
        .o_count         (w_bit_cnt),
        .o_rollover_flag (w_byte_done)
    );

    // Run of sampled ones deliberately survives byte boundaries.
    always_ff @(posedge clk) begin
        if (rst || w_leave) begin
            r_ones_cnt <= '0;
        end else if (w_sample) begin
            if (w_stuff || !d_orig) begin
                r_ones_cnt <= '0;
            end else begin
                r_ones_cnt <= r_ones_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_received <= 1'b0;
        end else begin
            r_byte_received <= w_byte_done && enable_timer;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = enable_timer ? RUN : IDLE;
            RUN:     w_state_nxt = enable_timer ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_enable = 1'b0;
        stuff_err    = 1'b0;
        if (w_run) begin
            shift_enable = w_accept;
            stuff_err    = w_stuff && d_orig;
        end
    end

    assign byte_received = r_byte_received;
    assign bit_cnt       = w_bit_cnt;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Bench for rx_bit_timer: reset/startup vector table, directed timing sequences, randomized run against a reference model.
module tb_rx_bit_timer;

    localparam int CPB = 8;
    localparam int SP  = 3;
    localparam int BPB = 8;
    localparam int LIM = 6;

    logic       clk = 1'b0;
    logic       rst, enable_timer, d_edge, d_orig;
    logic       shift_enable, byte_received, stuff_err;
    logic [3:0] bit_cnt;

    always #5 clk = ~clk;

    rx_bit_timer dut (
        .clk           (clk),
        .rst           (rst),
        .enable_timer  (enable_timer),
        .d_edge        (d_edge),
        .d_orig        (d_orig),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .stuff_err     (stuff_err),
        .bit_cnt       (bit_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: bit phase since last resync, run of sampled ones, accepted bits, pending byte strobe.
    bit m_run;
    int m_phase, m_ones, m_bits;
    bit m_byte;

    logic       o_shift, o_byte, o_err;
    logic [3:0] o_bits;

    int sh_q[$];
    int by_q[$];
    int er_q[$];

    typedef struct {
        logic       r, e, de, dor;
        logic       xs, xb, xe;
        logic [3:0] xbits;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_phase = 0; m_ones = 0; m_bits = 0; m_byte = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable_timer = 1'b0; d_edge = 1'b0; d_orig = 1'b0;
        @(posedge clk); #1;
        model_reset();
    endtask

    // One clock: drive, compare at mid-cycle against the model, advance the model across the edge.
    task automatic cyc(input logic r, input logic e, input logic de, input logic dor, input string tag);
        bit samp, stf, xs, xe;
        rst = r; enable_timer = e; d_edge = de; d_orig = dor;
        #4;
        samp = m_run && (m_phase == SP);
        stf  = samp && (m_ones == LIM);
        xs   = samp && !stf;
        xe   = stf && dor;
        o_shift = shift_enable; o_byte = byte_received; o_err = stuff_err; o_bits = bit_cnt;
        check({tag, " shift_enable"},  32'(o_shift), 32'(xs));
        check({tag, " byte_received"}, 32'(o_byte),  32'(m_byte));
        check({tag, " stuff_err"},     32'(o_err),   32'(xe));
        check({tag, " bit_cnt"},       32'(o_bits),  32'(m_bits));
        if (r) begin
            model_reset();
        end else if (!m_run) begin
            m_run  = e;
            m_byte = 0;
        end else if (!e) begin
            model_reset();
        end else begin
            m_byte = 0;
            if (xs) begin
                m_ones = dor ? m_ones + 1 : 0;
                m_bits = m_bits + 1;
                if (m_bits == BPB) begin
                    m_bits = 0;
                    m_byte = 1;
                end
            end else if (stf) begin
                m_ones = 0;
            end
            m_phase = de ? 0 : (m_phase + 1) % CPB;
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        sh_q.delete(); by_q.delete(); er_q.delete();
    endtask

    task automatic log_strobes(input int k);
        if (o_shift) sh_q.push_back(k);
        if (o_byte)  by_q.push_back(k);
        if (o_err)   er_q.push_back(k);
    endtask

    initial begin
        logic [3:0] bits_a, bits_b;
        logic       s_a, e_a;
        int         quiet;
        logic       re, rr, rde, rdor;

        do_reset();

        // Reset with edges toggling, then startup of the first bit, then reset mid-run.
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].r, tbl[i].e, tbl[i].de, tbl[i].dor, $sformatf("vec%0d", i));
            check($sformatf("tbl%0d shift", i), 32'(o_shift), 32'(tbl[i].xs));
            check($sformatf("tbl%0d byte", i),  32'(o_byte),  32'(tbl[i].xb));
            check($sformatf("tbl%0d err", i),   32'(o_err),   32'(tbl[i].xe));
            check($sformatf("tbl%0d bits", i),  32'(o_bits),  32'(tbl[i].xbits));
        end

        // Free-running byte of zeros.
        do_reset(); clear_logs();
        for (int k = 0; k <= 62; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, "t2");
            log_strobes(k);
            if (k == 60) bits_a = o_bits;
            if (k == 61) bits_b = o_bits;
        end
        check("t2 shift_count", 32'(sh_q.size()), 32'd8);
        for (int i = 0; i < sh_q.size() && i < 8; i++)
            check($sformatf("t2 shift_cycle%0d", i), 32'(sh_q[i]), 32'(4 + 8 * i));
        check("t2 byte_count", 32'(by_q.size()), 32'd1);
        if (by_q.size() > 0) check("t2 byte_cycle", 32'(by_q[0]), 32'd61);
        check("t2 bits_at60", 32'(bits_a), 32'd7);
        check("t2 bits_at61", 32'(bits_b), 32'd0);

        // Resync on a data edge in cycle 6.
        do_reset(); clear_logs();
        for (int k = 0; k <= 30; k++) begin
            cyc(1'b0, 1'b1, logic'(k == 6), 1'b0, "t3");
            log_strobes(k);
        end
        check("t3 shift_count", 32'(sh_q.size()), 32'd4);
        if (sh_q.size() >= 4) begin
            check("t3 shift0", 32'(sh_q[0]), 32'd4);
            check("t3 shift1", 32'(sh_q[1]), 32'd10);
            check("t3 shift2", 32'(sh_q[2]), 32'd18);
            check("t3 shift3", 32'(sh_q[3]), 32'd26);
        end

        // Six ones then zeros: seventh sample is a clean stuff bit.
        do_reset(); clear_logs();
        for (int k = 0; k <= 63; k++) begin
            cyc(1'b0, 1'b1, 1'b0, logic'((k / 8) < 6), "t4");
            log_strobes(k);
            if (k == 52) begin s_a = o_shift; e_a = o_err; bits_a = o_bits; end
            if (k == 61) bits_b = o_bits;
        end
        check("t4 shift_count", 32'(sh_q.size()), 32'd7);
        check("t4 err_count", 32'(er_q.size()), 32'd0);
        check("t4 stuff_shift", 32'(s_a), 32'd0);
        check("t4 stuff_err", 32'(e_a), 32'd0);
        check("t4 bits_held", 32'(bits_a), 32'd6);
        check("t4 bits_after", 32'(bits_b), 32'd7);

        // Continuous ones: violation at the 7th sample, run restarts, next violation at the 14th.
        do_reset(); clear_logs();
        for (int k = 0; k <= 111; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1, "t5");
            log_strobes(k);
        end
        check("t5 err_count", 32'(er_q.size()), 32'd2);
        if (er_q.size() >= 2) begin
            check("t5 err0", 32'(er_q[0]), 32'd52);
            check("t5 err1", 32'(er_q[1]), 32'd108);
        end
        check("t5 shift_count", 32'(sh_q.size()), 32'd12);
        check("t5 byte_count", 32'(by_q.size()), 32'd1);
        if (by_q.size() > 0) check("t5 byte_cycle", 32'(by_q[0]), 32'd69);

        // Drop enable after three bits, then restart a full byte.
        do_reset(); clear_logs();
        quiet = 0;
        for (int k = 0; k <= 95; k++) begin
            cyc(1'b0, logic'(k < 22 || k >= 31), 1'b0, 1'b0, "t6");
            log_strobes(k);
            if (k == 22) bits_a = o_bits;
            if (k == 23) bits_b = o_bits;
            if (k >= 23 && k <= 30 && (o_shift || o_byte || o_err)) quiet++;
        end
        check("t6 bits_before_drop", 32'(bits_a), 32'd3);
        check("t6 bits_after_drop", 32'(bits_b), 32'd0);
        check("t6 idle_strobes", 32'(quiet), 32'd0);
        check("t6 shift_count", 32'(sh_q.size()), 32'd11);
        if (sh_q.size() >= 4) check("t6 first_after_reenable", 32'(sh_q[3]), 32'd35);
        check("t6 byte_count", 32'(by_q.size()), 32'd1);
        if (by_q.size() > 0) check("t6 byte_cycle", 32'(by_q[0]), 32'd92);

        // Randomized traffic against the model.
        do_reset();
        re = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) re = ~re;
            rr   = logic'($urandom_range(0, 999) == 0);
            rde  = logic'($urandom_range(0, 15) == 0);
            rdor = logic'($urandom_range(0, 3) != 0);
            cyc(rr, re, rde, rdor, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
